fmult_accum_seq: RTL
====================

Name: fmult_accum_seq

Overview:
- Sequential G.726 signal-estimator datapath: computes signal estimate SE and partial estimate SEZ from 6 zero-predictor and 2 pole-predictor terms.
- One shared FMULT engine; 8 products accumulated over 8 cycles.
- Sits directly upstream of the reconstruction adder. That adder consumes SE[14:0] and adds it to DQ to form SR.

Parameters:
- NPROD, 8, number of products per estimate (fixed: 6 zero + 2 pole; other values unsupported).
- NZERO, 6, number of zero-predictor terms, accumulated first.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- B1..B6  in  16 each  zero-predictor coefficients, 2's complement Q14.
- DQ1..DQ6  in  11 each  delayed quantized difference, float {S[10], EXP[9:6], MANT[5:0]}.
- A1, A2  in  16 each  pole-predictor coefficients, 2's complement Q14.
- SR1, SR2  in  11 each  delayed reconstructed signal, same float format.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; SE/SEZ valid.
- SE  out  15  signal estimate, 2's complement.
- SEZ  out  15  partial signal estimate, 2's complement.

Behaviour:
- Reset is asynchronous and active-low; the clock and reset ports are clk and reset_n. During reset: busy=0, done=0, SE=0, SEZ=0, accumulator=0, state=IDLE.
- States:
  - IDLE: on start=1, capture all 16 operands into local registers, clear the accumulator, set idx=0 -> ZERO.
  - ZERO: each cycle acc += WB[idx+1] (mod 2^16). After idx=5: latch SEZI=acc, idx=0 -> POLE.
  - POLE: acc += WA[idx+1]. After idx=1 -> DONE.
  - DONE: SE<=acc[15:1], SEZ<=SEZI[15:1], done=1 for this cycle -> IDLE.
- Latency: start sampled at edge 0; done high in the cycle following edge 9. busy covers edges 1..9.
- Operands are captured at start. Input changes while busy have no effect.
- start while busy, or in the DONE cycle, is ignored; it is not queued.
- SE/SEZ hold their values between done pulses.
- FMULT(An, SRn), all unsigned 16-bit arithmetic with wrap:
  - AnS=An[15]. AnMAG = AnS ? (-(An>>2)) & 8191 : An>>2 (logical shift).
  - AnEXP = bit-length of AnMAG (0..13).
  - AnMANT = AnMAG==0 ? 32 : (AnMAG<<6)>>AnEXP.
  - WS = AnS ^ SRn[10]. WEXP = AnEXP + SRn[9:6] (5 bits).
  - WMANT = (SRn[5:0]*AnMANT + 48)>>4.
  - WMAG = WEXP<=26 ? (WMANT<<7)>>(26-WEXP) : ((WMANT<<7)<<(WEXP-26)) & 32767.
  - W = WS ? (65536-WMAG) mod 65536 : WMAG.
- Accumulator is 16 bits and wraps; there is no saturation.
- Reset asserted mid-operation aborts immediately. The next start begins a fresh estimate.

Optional Feature:
- FMULT_PIPE_EN defined: a register stage is inserted after WMANT/WEXP/WS inside the FMULT path.
  - Accumulation trails by one cycle.
  - done lands in the cycle after edge 10; busy covers edges 1..10.
  - Results are bit-identical to the unpipelined build.
- FMULT_PIPE_EN undefined: purely combinational FMULT, latency as stated above.

Decomposition:
- Shared package:
  - width constants: COEF_W=16, FLT_W=11, SIG_W=15, ACC_W=16.
  - state enum {IDLE, ZERO, POLE, DONE}.
  - float field slice constants.
- Sub-module fmult_core: combinational FMULT, An[15:0] + SRn[10:0] -> W[15:0]. Instantiated once and muxed by state/idx. It is reusable elsewhere in the codebase.

Test Plan:
- All coefficients 0, arbitrary floats, start -> done at edge 9, SE=0, SEZ=0, busy high edges 1..9.
- A1=16384, SR1={0,5,32}, all other coefficients 0 -> WA1=33, SE=16, SEZ=0.
- B1=16384, DQ1={0,5,32}, all others 0 -> SEZ=16, SE=16.
- A1=49152 (-16384), SR1={0,5,32}, others 0 -> WA1=65503, SE=32751, SEZ=0.
- start pulsed at edges 3 and 9 of a run, B1 changed mid-run -> a single done; results from operands captured at edge 0. A start in IDLE after done is accepted.
- reset_n low at edge 5 -> busy=0, done=0, SE=SEZ=0 asynchronously. The following start produces the correct result. Repeat with FMULT_PIPE_EN defined: identical values, done one cycle later.

Source files
------------

// File: rtl/fmult_accum_seq_pkg.sv
// Shared types and constants for the G.726 signal-estimator datapath (fmult_accum_seq).
// The optional FMULT pipeline stage is selected by the FMULT_PIPE_EN macro in the top.
package fmult_accum_seq_pkg;

  localparam int COEF_W = 16;
  localparam int FLT_W  = 11;
  localparam int SIG_W  = 15;
  localparam int ACC_W  = 16;

  localparam int NPROD = 8;
  localparam int NZERO = 6;
  localparam int NPOLE = NPROD - NZERO;

  // Float operand layout {sign, exponent[3:0], mantissa[5:0]}
  localparam int FLT_SIGN    = 10;
  localparam int FLT_EXP_HI  = 9;
  localparam int FLT_EXP_LO  = 6;
  localparam int FLT_MANT_HI = 5;
  localparam int FLT_MANT_LO = 0;

  typedef enum logic [1:0] {IDLE, ZERO, POLE, DONE} state_t;

  function automatic logic [3:0] bit_len(input logic [12:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 13; i++) begin
      if (m[i]) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fmult_accum_seq_fmult.sv
// fmult_core: combinational G.726 FMULT, split into a front half (sign/exp/mantissa)
// and a back half (denormalise/negate) so a caller may register between them.
module fmult_core
  import fmult_accum_seq_pkg::*;
(
  input  logic [COEF_W-1:0] an,
  input  logic [FLT_W-1:0]  srn,
  output logic              ws,
  output logic [4:0]        wexp,
  output logic [7:0]        wmant,
  input  logic              ws_r,
  input  logic [4:0]        wexp_r,
  input  logic [7:0]        wmant_r,
  output logic [COEF_W-1:0] w
);

  logic        ans;
  logic [12:0] anmag;
  logic [3:0]  anexp;
  logic [5:0]  anmant;
  logic [16:0] base;
  logic [14:0] wmag;

  // NOTE: every combinational output is assigned on every path so no latch is inferred.
  always_comb begin
    ans    = an[COEF_W-1];
    anmag  = ans ? 13'(-(an >> 2)) : 13'(an >> 2);
    anexp  = bit_len(anmag);
    anmant = (anmag == '0) ? 6'd32 : 6'(({anmag, 6'b0}) >> anexp);
    ws     = ans ^ srn[FLT_SIGN];
    wexp   = {1'b0, anexp} + {1'b0, srn[FLT_EXP_HI:FLT_EXP_LO]};
    wmant  = 8'((12'(srn[FLT_MANT_HI:FLT_MANT_LO]) * 12'(anmant) + 12'd48) >> 4);
  end

  always_comb begin
    base = {2'b00, wmant_r, 7'b0};
    if (wexp_r <= 5'd26) wmag = 15'(base >> (5'd26 - wexp_r));
    else                 wmag = 15'(base << (wexp_r - 5'd26));
    w = ws_r ? 16'(-{1'b0, wmag}) : {1'b0, wmag};
  end

endmodule

// File: rtl/fmult_accum_seq.sv
// Sequential signal estimator: one shared FMULT, 6 zero + 2 pole products accumulated
// into SE/SEZ. Define FMULT_PIPE_EN to register the FMULT midpoint (one extra cycle).
module fmult_accum_seq
  import fmult_accum_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [COEF_W-1:0] B1, B2, B3, B4, B5, B6,
  input  logic [FLT_W-1:0]  DQ1, DQ2, DQ3, DQ4, DQ5, DQ6,
  input  logic [COEF_W-1:0] A1, A2,
  input  logic [FLT_W-1:0]  SR1, SR2,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  SE,
  output logic [SIG_W-1:0]  SEZ
);

`ifdef FMULT_PIPE_EN
  localparam int POLE_LAST = NPOLE;      // one drain cycle for the registered product
`else
  localparam int POLE_LAST = NPOLE - 1;
`endif

  state_t state, state_nxt;
  logic [2:0] idx;

  logic [COEF_W-1:0] b [NZERO];
  logic [FLT_W-1:0]  dq[NZERO];
  logic [COEF_W-1:0] a [NPOLE];
  logic [FLT_W-1:0]  sr[NPOLE];

  logic [ACC_W-1:0]  acc, acc_sum;
  logic [SIG_W-1:0]  sezi;

  logic load, acc_en, sezi_en, fin, busy_nxt, done_nxt;
  logic acc_en_x, sezi_en_x;

  logic [COEF_W-1:0] an_sel;
  logic [FLT_W-1:0]  sr_sel;
  logic              ws, ws_x;
  logic [4:0]        wexp, wexp_x;
  logic [7:0]        wmant, wmant_x;
  logic [COEF_W-1:0] w;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !done)              state_nxt = ZERO;
      ZERO: if (idx == 3'(NZERO - 1))        state_nxt = POLE;
      POLE: if (idx == 3'(POLE_LAST))        state_nxt = DONE;
      DONE:                                  state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // A start during the done pulse is treated as arriving while busy.
  always_comb begin
    load     = (state == IDLE) && start && !done;
    acc_en   = (state == ZERO) || ((state == POLE) && (idx < 3'(NPOLE)));
    sezi_en  = (state == ZERO) && (idx == 3'(NZERO - 1));
    fin      = (state == DONE);
    busy_nxt = (state != IDLE);
    done_nxt = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                idx <= '0;
    else if (state_nxt != state) idx <= '0;
    else                         idx <= 3'(idx + 3'd1);
  end

  // NOTE: operand registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      b[0] <= B1;  b[1] <= B2;  b[2] <= B3;  b[3] <= B4;  b[4] <= B5;  b[5] <= B6;
      dq[0] <= DQ1; dq[1] <= DQ2; dq[2] <= DQ3; dq[3] <= DQ4; dq[4] <= DQ5; dq[5] <= DQ6;
      a[0] <= A1;  a[1] <= A2;
      sr[0] <= SR1; sr[1] <= SR2;
    end
  end

  always_comb begin
    an_sel = '0;
    sr_sel = '0;
    case (state)
      ZERO: begin an_sel = b[idx];    sr_sel = dq[idx];    end
      POLE: begin an_sel = a[idx[0]]; sr_sel = sr[idx[0]]; end
      default: ;
    endcase
  end

  fmult_core u_fmult (
    .an      (an_sel),
    .srn     (sr_sel),
    .ws      (ws),
    .wexp    (wexp),
    .wmant   (wmant),
    .ws_r    (ws_x),
    .wexp_r  (wexp_x),
    .wmant_r (wmant_x),
    .w       (w)
  );

`ifdef FMULT_PIPE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_x      <= 1'b0;
      wexp_x    <= '0;
      wmant_x   <= '0;
      acc_en_x  <= 1'b0;
      sezi_en_x <= 1'b0;
    end else begin
      ws_x      <= ws;
      wexp_x    <= wexp;
      wmant_x   <= wmant;
      acc_en_x  <= acc_en;
      sezi_en_x <= sezi_en;
    end
  end
`else
  assign ws_x      = ws;
  assign wexp_x    = wexp;
  assign wmant_x   = wmant;
  assign acc_en_x  = acc_en;
  assign sezi_en_x = sezi_en;
`endif

  assign acc_sum = acc + w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      sezi <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      SE   <= '0;
      SEZ  <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (load)          acc <= '0;
      else if (acc_en_x) acc <= acc_sum;
      if (sezi_en_x)     sezi <= acc_sum[ACC_W-1:1];
      if (fin) begin
        SE  <= acc[ACC_W-1:1];
        SEZ <= sezi;
      end
    end
  end

endmodule
